// File: rtl/rt_tstamp_pkg.sv
// Shared constants and the timestamp FIFO entry layout
// for the event timestamp capture stage.
package rt_tstamp_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  localparam int CNT_W_DEF = 32;
  localparam int DEPTH_DEF = 8;

  // Packing order matches the FIFO word {first, delta, tstamp}
  typedef struct packed {
    logic                 first;
    logic [CNT_W_DEF-1:0] delta;
    logic [CNT_W_DEF-1:0] tstamp;
  } tstamp_entry_t;

endpackage

// File: rtl/rt_sync_fifo.sv
// Show-ahead synchronous FIFO with clear,
// accepting a push while full if a pop happens in the same cycle.
module rt_sync_fifo #(
  parameter  int W     = 65,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         rt_i_clk,
  input  logic         rt_i_rst_n,
  input  logic         rt_i_clr,
  input  logic         rt_i_push,
  input  logic         rt_i_pop,
  input  logic [W-1:0] rt_i_wdata,
  output logic [W-1:0] rt_o_rdata,
  output logic         rt_o_full,
  output logic         rt_o_empty,
  output logic [AW:0]  rt_o_level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign rt_o_empty = (rt_o_level == '0);
  assign rt_o_full  = (rt_o_level == (AW+1)'(DEPTH));
  assign do_pop     = rt_i_pop & ~rt_o_empty;
  assign do_push    = rt_i_push & (~rt_o_full | do_pop);
  assign rt_o_rdata = rt_o_empty ? '0 : mem[rptr];

  always_ff @(posedge rt_i_clk or negedge rt_i_rst_n) begin
    if (!rt_i_rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      rt_o_level <= '0;
    end else if (rt_i_clr) begin
      wptr       <= '0;
      rptr       <= '0;
      rt_o_level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      rt_o_level <= rt_o_level
                  + (AW+1)'(do_push)
                  - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: reads are masked while empty
  always_ff @(posedge rt_i_clk) begin
    if (do_push && !rt_i_clr) mem[wptr] <= rt_i_wdata;
  end

endmodule

// File: rtl/rt_cnt_tstamp.sv
// Event timestamp capture: synchronise, edge detect, snapshot
// the counter with delta to the previous capture, queue in a FIFO.
module rt_cnt_tstamp
  import rt_tstamp_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_SEL    = EDGE_RISE,
  parameter int DROP_W      = 16
) (
  input  logic                     rt_i_clk,
  input  logic                     rt_i_rst_n,
  input  logic [CNT_W-1:0]         rt_i_cnt,
  input  logic                     rt_i_evt,
  input  logic                     rt_i_en,
  input  logic                     rt_i_clr,
  output logic                     rt_o_valid,
  input  logic                     rt_i_ready,
  output logic [CNT_W-1:0]         rt_o_tstamp,
  output logic [CNT_W-1:0]         rt_o_delta,
  output logic                     rt_o_first,
  output logic [$clog2(DEPTH):0]   rt_o_level,
  output logic                     rt_o_ovf,
  output logic [DROP_W-1:0]        rt_o_drop_cnt
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   s_d;
  logic                   edge_det;
  logic                   cap;
  logic                   pop;
  logic                   push;
  logic                   drop;
  logic                   full;
  logic                   empty;
  logic                   first_pend;
  logic [CNT_W-1:0]       last_ts;
  logic [CNT_W-1:0]       delta;
  logic [2*CNT_W:0]       wdata;
  logic [2*CNT_W:0]       rdata;

  assign s = sync[SYNC_STAGES-1];

  // History flop runs regardless of enable so enabling never fakes an edge
  always_ff @(posedge rt_i_clk or negedge rt_i_rst_n) begin
    if (!rt_i_rst_n) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rt_i_evt};
      s_d  <= s;
    end
  end

  always_comb begin
    edge_det = 1'b0;
    case (EDGE_SEL)
      EDGE_FALL: edge_det = ~s & s_d;
      EDGE_BOTH: edge_det = s ^ s_d;
      default:   edge_det = s & ~s_d;
    endcase
  end

  assign cap   = edge_det & rt_i_en;
  assign pop   = rt_o_valid & rt_i_ready;
  assign push  = cap & (~full | pop);
  assign drop  = cap & ~push;
  assign delta = first_pend ? '0 : rt_i_cnt - last_ts;
  assign wdata = {first_pend, delta, rt_i_cnt};

  always_ff @(posedge rt_i_clk or negedge rt_i_rst_n) begin
    if (!rt_i_rst_n) begin
      last_ts       <= '0;
      first_pend    <= 1'b1;
      rt_o_ovf      <= 1'b0;
      rt_o_drop_cnt <= '0;
    end else if (rt_i_clr) begin
      last_ts       <= '0;
      first_pend    <= 1'b1;
      rt_o_ovf      <= 1'b0;
      rt_o_drop_cnt <= '0;
    end else begin
      if (push) begin
        last_ts    <= rt_i_cnt;
        first_pend <= 1'b0;
      end
      if (drop) begin
        rt_o_ovf <= 1'b1;
        if (~&rt_o_drop_cnt) rt_o_drop_cnt <= rt_o_drop_cnt + 1'b1;
      end
    end
  end

  rt_sync_fifo #(
    .W     (2*CNT_W+1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .rt_i_clk   (rt_i_clk),
    .rt_i_rst_n (rt_i_rst_n),
    .rt_i_clr   (rt_i_clr),
    .rt_i_push  (push),
    .rt_i_pop   (pop),
    .rt_i_wdata (wdata),
    .rt_o_rdata (rdata),
    .rt_o_full  (full),
    .rt_o_empty (empty),
    .rt_o_level (rt_o_level)
  );

  assign rt_o_valid  = ~empty;
  assign rt_o_first  = rdata[2*CNT_W];
  assign rt_o_delta  = rdata[2*CNT_W-1:CNT_W];
  assign rt_o_tstamp = rdata[CNT_W-1:0];

endmodule

// File: tb/tb_rt_cnt_tstamp.sv
// Bench for rt_cnt_tstamp: directed scenarios plus random traffic
// against a queue-based model of the capture stage.
module tb_rt_cnt_tstamp;
  import rt_tstamp_pkg::*;

  localparam int SYNC  = 2;
  localparam int DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic [31:0] cnt;
  logic        evt;
  logic        en;
  logic        clr;
  logic        valid;
  logic        ready;
  logic [31:0] tstamp;
  logic [31:0] delta;
  logic        first;
  logic [3:0]  level;
  logic        ovf;
  logic [15:0] drop_cnt;

  int vec;
  int err;
  bit cnt_run;

  tstamp_entry_t mq[$];
  logic [31:0]   m_last;
  bit            m_first;
  bit            m_ovf;
  logic [15:0]   m_drop;
  logic [SYNC:0] hist;

  rt_cnt_tstamp #(
    .CNT_W       (32),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC),
    .EDGE_SEL    (EDGE_RISE),
    .DROP_W      (16)
  ) dut (
    .rt_i_clk      (clk),
    .rt_i_rst_n    (rst_n),
    .rt_i_cnt      (cnt),
    .rt_i_evt      (evt),
    .rt_i_en       (en),
    .rt_i_clr      (clr),
    .rt_o_valid    (valid),
    .rt_i_ready    (ready),
    .rt_o_tstamp   (tstamp),
    .rt_o_delta    (delta),
    .rt_o_first    (first),
    .rt_o_level    (level),
    .rt_o_ovf      (ovf),
    .rt_o_drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_last  = '0;
    m_first = 1'b1;
    m_ovf   = 1'b0;
    m_drop  = '0;
    hist    = '0;
  endtask

  // Model: a pin edge reaches the capture decision SYNC+1 edges later
  task automatic tick();
    tstamp_entry_t e;
    bit cap;
    bit pop;
    bit ok;
    cap = hist[SYNC-1] && !hist[SYNC] && en;
    pop = (mq.size() != 0) && ready;
    if (clr) begin
      mq.delete();
      m_last  = '0;
      m_first = 1'b1;
      m_ovf   = 1'b0;
      m_drop  = '0;
    end else begin
      ok = cap && (mq.size() < DEPTH || pop);
      if (pop) void'(mq.pop_front());
      if (ok) begin
        e.first  = m_first;
        e.delta  = m_first ? 32'd0 : cnt - m_last;
        e.tstamp = cnt;
        mq.push_back(e);
        m_last  = cnt;
        m_first = 1'b0;
      end else if (cap) begin
        m_ovf = 1'b1;
        if (m_drop != 16'hFFFF) m_drop = m_drop + 1'b1;
      end
    end
    hist = {hist[SYNC-1:0], evt};
    @(posedge clk);
    #1;
    if (cnt_run) cnt = cnt + 1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Pulse evt so the capture samples the value "at"
  task automatic pulse(input logic [31:0] at);
    cnt_run = 1'b1;
    cnt = at - SYNC;
    evt = 1'b1;
    tick();
    tick();
    evt = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    vec++;
    if (valid !== 1'b0) begin
      err++; $display("FAIL reset_valid got %0b want 0", valid);
    end
    vec++;
    if (level !== 4'd0) begin
      err++; $display("FAIL reset_level got %0d want 0", level);
    end
    vec++;
    if (ovf !== 1'b0 || drop_cnt !== 16'd0) begin
      err++; $display("FAIL reset_ovf got %0b/%0d want 0/0", ovf, drop_cnt);
    end
    vec++;
    if (tstamp !== 32'd0 || delta !== 32'd0 || first !== 1'b0) begin
      err++;
      $display("FAIL reset_head got %h/%h/%0b want 0/0/0",
               tstamp, delta, first);
    end
  endtask

  task automatic test_first_capture();
    int n;
    en = 1'b1;
    ready = 1'b0;
    cnt_run = 1'b0;
    cnt = 32'd100;
    evt = 1'b1;
    n = 0;
    while (!valid && n < 10) begin
      tick();
      n++;
    end
    vec++;
    if (n != SYNC + 1) begin
      err++; $display("FAIL first_latency got %0d want %0d", n, SYNC + 1);
    end
    vec++;
    if (tstamp !== 32'd100 || first !== 1'b1 || delta !== 32'd0) begin
      err++;
      $display("FAIL first_head got %0d/%0b/%0d want 100/1/0",
               tstamp, first, delta);
    end
    vec++;
    if (level !== 4'd1) begin
      err++; $display("FAIL first_level got %0d want 1", level);
    end
    evt = 1'b0;
    tick();
    tick();
    do_clr();
  endtask

  task automatic test_delta();
    ready = 1'b0;
    pulse(32'd1000);
    pulse(32'd1250);
    vec++;
    if (level !== 4'd2 || tstamp !== 32'd1000 || first !== 1'b1) begin
      err++;
      $display("FAIL delta_first got lvl %0d ts %0d f %0b want 2/1000/1",
               level, tstamp, first);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    vec++;
    if (tstamp !== 32'd1250 || delta !== 32'd250 || first !== 1'b0) begin
      err++;
      $display("FAIL delta_second got %0d/%0d/%0b want 1250/250/0",
               tstamp, delta, first);
    end
    do_clr();
  endtask

  task automatic test_wrap();
    ready = 1'b0;
    pulse(32'hFFFF_FFF0);
    pulse(32'h0000_0010);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    vec++;
    if (tstamp !== 32'h10 || delta !== 32'h20) begin
      err++;
      $display("FAIL wrap_delta got %h/%h want 00000010/00000020",
               tstamp, delta);
    end
    do_clr();
  endtask

  task automatic test_overflow();
    logic [31:0] want;
    ready = 1'b0;
    for (int i = 0; i < 10; i++) pulse(32'd5000 + 32'(i) * 37);
    vec++;
    if (level !== 4'd8 || ovf !== 1'b1 || drop_cnt !== 16'd2) begin
      err++;
      $display("FAIL ovf_fill got lvl %0d ovf %0b drop %0d want 8/1/2",
               level, ovf, drop_cnt);
    end
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      want = 32'd5000 + 32'(i) * 37;
      vec++;
      if (!valid || tstamp !== want) begin
        err++;
        $display("FAIL ovf_drain[%0d] got v %0b ts %0d want 1/%0d",
                 i, valid, tstamp, want);
      end
      tick();
    end
    ready = 1'b0;
    vec++;
    if (level !== 4'd0 || ovf !== 1'b1) begin
      err++;
      $display("FAIL ovf_sticky got lvl %0d ovf %0b want 0/1", level, ovf);
    end
    pulse(32'd9000);
    want = 32'd9000 - (32'd5000 + 32'd7 * 37);
    vec++;
    if (delta !== want || first !== 1'b0) begin
      err++;
      $display("FAIL ovf_next_delta got %0d/%0b want %0d/0",
               delta, first, want);
    end
    do_clr();
  endtask

  task automatic test_full_pop();
    ready = 1'b0;
    for (int i = 0; i < 8; i++) pulse(32'd6000 + 32'(i) * 10);
    cnt = 32'd7000 - SYNC;
    evt = 1'b1;
    tick();
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    vec++;
    if (level !== 4'd8 || ovf !== 1'b0 || drop_cnt !== 16'd0) begin
      err++;
      $display("FAIL full_pop got lvl %0d ovf %0b drop %0d want 8/0/0",
               level, ovf, drop_cnt);
    end
    vec++;
    if (tstamp !== 32'd6010) begin
      err++; $display("FAIL full_pop_head got %0d want 6010", tstamp);
    end
    evt = 1'b0;
    tick();
    tick();
    do_clr();
  endtask

  task automatic test_enable();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      evt = ~evt;
      tick();
      tick();
    end
    tick();
    tick();
    en = 1'b1;
    repeat (6) tick();
    vec++;
    if (level !== 4'd0 || valid !== 1'b0) begin
      err++;
      $display("FAIL enable_nocap got lvl %0d v %0b want 0/0", level, valid);
    end
    evt = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_clr_cap();
    ready = 1'b0;
    pulse(32'd350);
    cnt = 32'd300 - SYNC;
    evt = 1'b1;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    vec++;
    if (level !== 4'd0 || valid !== 1'b0) begin
      err++;
      $display("FAIL clr_cap got lvl %0d v %0b want 0/0", level, valid);
    end
    evt = 1'b0;
    tick();
    tick();
    pulse(32'd400);
    vec++;
    if (first !== 1'b1 || tstamp !== 32'd400 || delta !== 32'd0) begin
      err++;
      $display("FAIL clr_next got %0b/%0d/%0d want 1/400/0",
               first, tstamp, delta);
    end
    do_clr();
  endtask

  task automatic test_random();
    tstamp_entry_t h;
    cnt_run = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2) == 0) evt = ~evt;
      en    = ($urandom_range(7) != 0);
      ready = ($urandom_range(3) == 0);
      clr   = ($urandom_range(63) == 0);
      if ($urandom_range(15) == 0) cnt = $urandom;
      tick();
      h = (mq.size() != 0) ? mq[0] : '0;
      vec++;
      if (level !== 4'(mq.size()) || valid !== (mq.size() != 0)) begin
        err++;
        $display("FAIL rnd_level[%0d] got %0d want %0d", i, level, mq.size());
      end
      vec++;
      if (tstamp !== h.tstamp || delta !== h.delta || first !== h.first) begin
        err++;
        $display("FAIL rnd_head[%0d] got %h/%h/%0b want %h/%h/%0b", i,
                 tstamp, delta, first, h.tstamp, h.delta, h.first);
      end
      vec++;
      if (ovf !== m_ovf || drop_cnt !== m_drop) begin
        err++;
        $display("FAIL rnd_ovf[%0d] got %0b/%0d want %0b/%0d", i,
                 ovf, drop_cnt, m_ovf, m_drop);
      end
    end
    clr = 1'b0;
    ready = 1'b0;
    evt = 1'b0;
    en = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_async_reset();
    ready = 1'b0;
    pulse(32'd50);
    pulse(32'd60);
    #2;
    rst_n = 1'b0;
    #1;
    vec++;
    if (valid !== 1'b0 || level !== 4'd0 || tstamp !== 32'd0 ||
        delta !== 32'd0 || first !== 1'b0 || ovf !== 1'b0 ||
        drop_cnt !== 16'd0) begin
      err++;
      $display("FAIL async_rst got v %0b lvl %0d ts %h want all 0",
               valid, level, tstamp);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulse(32'd777);
    vec++;
    if (first !== 1'b1 || tstamp !== 32'd777 || level !== 4'd1) begin
      err++;
      $display("FAIL async_rst_next got %0b/%0d/%0d want 1/777/1",
               first, tstamp, level);
    end
  endtask

  initial begin
    vec = 0;
    err = 0;
    rst_n = 1'b0;
    cnt = '0;
    evt = 1'b0;
    en = 1'b0;
    clr = 1'b0;
    ready = 1'b0;
    cnt_run = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_first_capture();
    test_delta();
    test_wrap();
    test_overflow();
    test_full_pop();
    test_enable();
    test_clr_cap();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/rt_cnt_tstamp.md
Name: rt_cnt_tstamp

Overview:
Timestamp-capture stage sitting directly downstream of rt_32b_cnt and consuming its free-running rt_o_cnt value. On each qualified edge of an asynchronous event input, it snapshots the counter. It also computes the modular delta to the previous accepted snapshot. Both are queued in a small FIFO, and software/downstream logic drains them over a valid/ready interface.

Parameters:
CNT_W, 32, width of counter input, timestamp and delta
DEPTH, 8, FIFO entries (power of two, >=2)
SYNC_STAGES, 2, synchronizer flops on rt_i_evt (>=2)
EDGE_SEL, 0, 0 = rising, 1 = falling, 2 = both edges
DROP_W, 16, width of dropped-event counter

Ports:
rt_i_clk  in  1  clock, shared with rt_32b_cnt
rt_i_rst_n  in  1  asynchronous active-low reset
rt_i_cnt  in  CNT_W  free-running count (from rt_32b_cnt.rt_o_cnt)
rt_i_evt  in  1  asynchronous event input
rt_i_en  in  1  capture enable; edges ignored when low
rt_i_clr  in  1  synchronous clear of FIFO, flags and history
rt_o_valid  out  1  FIFO head valid
rt_i_ready  in  1  consumer accepts head when valid&ready
rt_o_tstamp  out  CNT_W  head timestamp
rt_o_delta  out  CNT_W  head delta (tstamp - previous accepted tstamp, mod 2^CNT_W)
rt_o_first  out  1  head is first capture since reset/clr; delta is 0 and meaningless
rt_o_level  out  clog2(DEPTH)+1  entries stored
rt_o_ovf  out  1  sticky: an event was dropped while full
rt_o_drop_cnt  out  DROP_W  dropped events, saturating

Behaviour:
- Reset (rt_i_rst_n low, async): sync chain and edge-history flop = 0; FIFO empty; rt_o_valid = 0; rt_o_level = 0; rt_o_ovf = 0; rt_o_drop_cnt = 0; last_ts = 0; first_pend = 1. rt_o_tstamp/rt_o_delta/rt_o_first = 0 while empty.
- Sync: rt_i_evt passes through SYNC_STAGES flops, giving s. One history flop holds s_d. The history flop updates every cycle regardless of rt_i_en, so enabling never creates a spurious edge.
- Edge detect is combinational on (s, s_d), per EDGE_SEL. Capture request cap = edge & rt_i_en.
- Latency: a pin edge meeting setup before clock k is detected in cycle k+SYNC_STAGES. rt_i_cnt is sampled at the end of that cycle. rt_o_valid rises the next cycle if the FIFO was empty.
- Delta = rt_i_cnt - last_ts, truncated to CNT_W (wrap-safe).
- First capture after reset/clr stores first=1 and delta=0, then clears first_pend.
- last_ts updates only on accepted captures.
- FIFO: show-ahead. rt_o_valid = (level != 0). Head fields are driven directly from the read pointer. Pop occurs on rt_o_valid & rt_i_ready.
- Push occurs on cap & (not full, or pop in the same cycle). Simultaneous push and pop when full: both happen, level unchanged.
- Simultaneous push and pop when empty: no pop (valid is 0), push accepted, level becomes 1.
- Full, cap, no pop: the event is dropped. rt_o_ovf is set; rt_o_drop_cnt increments and saturates at all-ones; last_ts and first_pend are unchanged.
- rt_i_clr has highest priority. Next cycle: FIFO empty, ovf = 0, drop_cnt = 0, first_pend = 1, last_ts = 0. A cap or pop in the clr cycle is discarded. The sync chain is not cleared.
- Pointers wrap modulo DEPTH. Level ranges 0..DEPTH.

Decomposition:
- Package rt_tstamp_pkg: EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2 constants; default CNT_W/DEPTH; entry struct {first, delta, tstamp} (width 2*CNT_W+1).
- Sub-module rt_sync_fifo (params W, DEPTH): show-ahead FIFO with push/pop/clr, full/empty/level, and push-when-full-with-pop allowed. The top level holds sync, edge detect, delta, first/ovf/drop logic.

Test Plan:
- Reset, rt_i_cnt = 100, en=1, one rising evt pulse, ready=0 -> valid high SYNC_STAGES+1 cycles after edge-clock; tstamp = value of rt_i_cnt at capture cycle; first=1; delta=0; level=1.
- rt_i_cnt tracks a counter; events at counts 1000, 1250 (ready=1) -> second entry tstamp=1250, delta=250, first=0.
- Wrap: captures with rt_i_cnt = 32'hFFFF_FFF0 then 32'h0000_0010 -> delta = 32'h0000_0020.
- ready=0, 10 events with DEPTH=8 -> level=8, ovf=1, drop_cnt=2. Drain -> 8 entries in order; ovf stays 1 until clr. Next capture's delta is relative to the 8th stored tstamp.
- Full FIFO, event coinciding with a pop -> push accepted, level stays 8, ovf unchanged.
- Edge cases: en=0 while evt toggles, then en=1 with evt already high -> no capture. rt_i_clr asserted together with a cap -> FIFO empty, first=1 on next capture. Async rt_i_rst_n low mid-stream -> all outputs 0 immediately.
